remind_alert: RTL and testbench

- Consumer end of the reminder interface. Takes the one-cycle remindSignal pulse and the live 4-bit water_level, and turns them into user-facing outputs: an LED and a buzzer.
- The alert escalates if it is ignored. It clears when the user acknowledges it or when the user drinks, meaning water_level drops.
- A missed-reminder tally is kept for the display.
- Sits between the reminder counter and the board LED/buzzer pins.

---
 rtl/remind_pkg.sv | 22 ++
 rtl/blink_tick.sv | 42 ++++
 rtl/remind_alert.sv | 152 +++++++++++++++
 tb/tb_remind_alert.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remind_pkg.sv
// ============================================================================
// Module   : remind_pkg
// Brief    : Shared state encoding and constants for the reminder alert block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package remind_pkg;

  localparam int         WATER_W    = 4;
  localparam logic [3:0] MISSED_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALERT   = 2'd1,
    URGENT  = 2'd2,
    HOLDOFF = 2'd3
  } alert_state_t;

endpackage

`default_nettype wire

// File: rtl/blink_tick.sv
// ============================================================================
// Module   : blink_tick
// Brief    : Free-running phase counter emitting a one-cycle tick every BLINK_DIV cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blink_tick #(
  parameter int BLINK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int             PHASE_W = $clog2(BLINK_DIV + 1);
  localparam logic [PHASE_W-1:0] C_LAST = PHASE_W'(BLINK_DIV - 1);

  logic [PHASE_W-1:0] phase_d, phase_q;

  // clear restarts the half-period so the first tick lands BLINK_DIV cycles later
  always_comb begin
    phase_d = phase_q + 1'b1;
    if (clear || (phase_q == C_LAST)) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tick = (phase_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/remind_alert.sv
// ============================================================================
// Module   : remind_alert
// Brief    : Turns reminder pulses into an escalating LED/buzzer alert with missed tally.
// Revision : 1.0
// ============================================================================
`default_nettype none

module remind_alert
  import remind_pkg::*;
#(
  parameter int BLINK_DIV      = 4,
  parameter int ALERT_TIMEOUT  = 32,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               remindSignal,
  input  logic [WATER_W-1:0] water_level,
  input  logic               ack,
  output logic               led,
  output logic               buzzer,
  output logic               alert_active,
  output logic [3:0]         missed_count
);

  localparam int TMO_W  = $clog2(ALERT_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [TMO_W-1:0]  C_TMO_LAST  = TMO_W'(ALERT_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  alert_state_t       state_d, state_q;
  logic [TMO_W-1:0]   tmo_d, tmo_q;
  logic [HOLD_W-1:0]  hold_d, hold_q;
  logic               led_d, led_q;
  logic               buzzer_d, buzzer_q;
  logic               active_d, active_q;
  logic [3:0]         missed_d, missed_q;
  logic               ack_q;
  logic [WATER_W-1:0] level_q;

  logic ack_rise, drop, clr, tick, blink_clear;

  assign ack_rise    = ack & ~ack_q;
  assign drop        = (level_q > water_level);
  assign clr         = ack_rise | drop;
  // every state change restarts the blink phase so LED/buzzer start a full half-period
  assign blink_clear = (state_d != state_q);

  blink_tick #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk   (clk),
    .reset (reset),
    .clear (blink_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    hold_d   = hold_q;
    led_d    = led_q;
    buzzer_d = buzzer_q;
    active_d = active_q;
    missed_d = missed_q;
    case (state_q)
      IDLE: begin
        led_d    = 1'b0;
        buzzer_d = 1'b0;
        active_d = 1'b0;
        if (remindSignal) begin
          state_d  = ALERT;
          tmo_d    = '0;
          led_d    = 1'b1;
          active_d = 1'b1;
        end
      end
      ALERT: begin
        if (clr) begin
          state_d  = HOLDOFF;
          hold_d   = '0;
          led_d    = 1'b0;
          buzzer_d = 1'b0;
          active_d = 1'b0;
        end else if (tmo_q == C_TMO_LAST) begin
          state_d  = URGENT;
          led_d    = 1'b1;
          buzzer_d = 1'b1;
          if (missed_q != MISSED_MAX) begin
            missed_d = missed_q + 4'd1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tick) begin
            led_d = ~led_q;
          end
        end
      end
      URGENT: begin
        if (clr) begin
          state_d  = HOLDOFF;
          hold_d   = '0;
          led_d    = 1'b0;
          buzzer_d = 1'b0;
          active_d = 1'b0;
        end else if (tick) begin
          buzzer_d = ~buzzer_q;
        end
      end
      default: begin
        led_d    = 1'b0;
        buzzer_d = 1'b0;
        active_d = 1'b0;
        if (hold_q == C_HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      hold_q   <= '0;
      led_q    <= 1'b0;
      buzzer_q <= 1'b0;
      active_q <= 1'b0;
      missed_q <= '0;
      ack_q    <= 1'b0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
      led_q    <= led_d;
      buzzer_q <= buzzer_d;
      active_q <= active_d;
      missed_q <= missed_d;
      ack_q    <= ack;
      level_q  <= water_level;
    end
  end

  assign led          = led_q;
  assign buzzer       = buzzer_q;
  assign alert_active = active_q;
  assign missed_count = missed_q;

endmodule

`default_nettype wire

// File: tb/tb_remind_alert.sv
// ============================================================================
// Module   : tb_remind_alert
// Brief    : Self-checking bench for remind_alert against an elapsed-time reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_remind_alert;

  localparam int BD = 4;
  localparam int AT = 32;
  localparam int HO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       remindSignal = 1'b0;
  logic [3:0] water_level = 4'd0;
  logic       ack = 1'b0;
  logic       led, buzzer, alert_active;
  logic [3:0] missed_count;

  int checks = 0;
  int failures = 0;

  logic [3:0] wl = 4'd0;
  logic       ak = 1'b0;

  // reference model: mode 0 idle, 1 alert, 2 urgent, 3 holdoff; m_t = edges since entry
  int         m_mode = 0;
  int         m_t = 0;
  int         m_missed = 0;
  logic       m_pack = 1'b0;
  logic [3:0] m_plvl = 4'd0;

  always #5 clk = ~clk;

  remind_alert #(
    .BLINK_DIV     (BD),
    .ALERT_TIMEOUT (AT),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .remindSignal (remindSignal),
    .water_level  (water_level),
    .ack          (ack),
    .led          (led),
    .buzzer       (buzzer),
    .alert_active (alert_active),
    .missed_count (missed_count)
  );

  function automatic logic [6:0] exp_out();
    logic e_led, e_buz, e_act;
    e_led = (m_mode == 1) ? (((m_t / BD) % 2) == 0) : (m_mode == 2);
    e_buz = (m_mode == 2) ? (((m_t / BD) % 2) == 0) : 1'b0;
    e_act = (m_mode == 1) || (m_mode == 2);
    return {e_led, e_buz, e_act, 4'(m_missed)};
  endfunction

  function automatic logic [6:0] dut_out();
    return {led, buzzer, alert_active, missed_count};
  endfunction

  task automatic step(input logic r, input logic rs);
    logic clr;
    remindSignal = r;
    water_level  = wl;
    ack          = ak;
    reset        = rs;
    @(posedge clk);
    if (rs) begin
      m_mode = 0; m_t = 0; m_missed = 0; m_pack = 1'b0; m_plvl = 4'd0;
    end else begin
      clr = (ak && !m_pack) || (m_plvl > wl);
      case (m_mode)
        0: if (r) begin m_mode = 1; m_t = 0; end
        1: begin
          if (clr) begin m_mode = 3; m_t = 0; end
          else if (m_t + 1 == AT) begin
            m_mode = 2; m_t = 0;
            if (m_missed < 15) m_missed++;
          end else m_t++;
        end
        2: if (clr) begin m_mode = 3; m_t = 0; end else m_t++;
        default: if (m_t + 1 == HO) begin m_mode = 0; m_t = 0; end else m_t++;
      endcase
      m_pack = ak;
      m_plvl = wl;
    end
    #1;
    remindSignal = 1'b0;
  endtask

  task automatic test_reset();
    ak = 1'b0; wl = 4'd5;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (dut_out() !== 7'd0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", dut_out(), 7'd0);
    end
    step(1'b0, 1'b0);
    checks++;
    if (dut_out() !== exp_out()) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", dut_out(), exp_out());
    end
  endtask

  task automatic test_escalation();
    ak = 1'b0; wl = 4'd8;
    step(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if ({led, alert_active, buzzer} !== 3'b110) begin
      failures++; $display("FAIL esc_entry got=%b exp=110", {led, alert_active, buzzer});
    end
    for (int i = 1; i <= 44; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (dut_out() !== exp_out()) begin
        failures++; $display("FAIL esc_cycle%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (i == 4) begin
        checks++;
        if (led !== 1'b0) begin
          failures++; $display("FAIL esc_led_toggle got=%b exp=0", led);
        end
      end
      if (i == 32) begin
        checks++;
        if (dut_out() !== {3'b111, 4'd1}) begin
          failures++; $display("FAIL esc_urgent got=%b exp=%b", dut_out(), {3'b111, 4'd1});
        end
      end
      if (i == 36) begin
        checks++;
        if ({led, buzzer} !== 2'b10) begin
          failures++; $display("FAIL esc_buzz_toggle got=%b exp=10", {led, buzzer});
        end
      end
    end
  endtask

  task automatic test_ack_holdoff();
    ak = 1'b0; wl = 4'd8;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    ak = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if ({led, alert_active} !== 2'b00) begin
      failures++; $display("FAIL ack_clear got=%b exp=00", {led, alert_active});
    end
    ak = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step((j == 3) || (j == 10), 1'b0);
      checks++;
      if (dut_out() !== exp_out()) begin
        failures++; $display("FAIL holdoff_cycle%0d got=%b exp=%b", j, dut_out(), exp_out());
      end
      if (j == 3) begin
        checks++;
        if (alert_active !== 1'b0) begin
          failures++; $display("FAIL holdoff_drop got=%b exp=0", alert_active);
        end
      end
      if (j == 10) begin
        checks++;
        if ({led, alert_active} !== 2'b11) begin
          failures++; $display("FAIL holdoff_reenter got=%b exp=11", {led, alert_active});
        end
      end
    end
  endtask

  task automatic test_drop();
    ak = 1'b0; wl = 4'd8;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 34; i++) step(1'b0, 1'b0);
    wl = 4'd7;
    step(1'b0, 1'b0);
    checks++;
    if ({led, buzzer, alert_active} !== 3'b000) begin
      failures++; $display("FAIL drop_urgent got=%b exp=000", {led, buzzer, alert_active});
    end
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    wl = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ((alert_active !== 1'b1) || (dut_out() !== exp_out())) begin
        failures++; $display("FAIL rise_no_clear got=%b exp=%b", dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_ack_held();
    ak = 1'b0; wl = 4'd8;
    step(1'b0, 1'b1);
    ak = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    ak = 1'b0;
    step(1'b0, 1'b0);
    checks++;
    if (alert_active !== 1'b1) begin
      failures++; $display("FAIL ack_held got=%b exp=1", alert_active);
    end
    ak = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if (alert_active !== 1'b0) begin
      failures++; $display("FAIL ack_reraise got=%b exp=0", alert_active);
    end
  endtask

  task automatic test_saturation();
    ak = 1'b0; wl = 4'd8;
    step(1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < AT; i++) step(1'b0, 1'b0);
      checks++;
      if ((missed_count !== 4'((k > 15) ? 15 : k)) || (dut_out() !== exp_out())) begin
        failures++; $display("FAIL missed_after%0d got=%0d exp=%0d", k, missed_count, (k > 15) ? 15 : k);
      end
      if (k < 16) begin
        ak = 1'b1;
        step(1'b0, 1'b0);
        ak = 1'b0;
        for (int i = 0; i < HO + 1; i++) step(1'b0, 1'b0);
      end
    end
    step(1'b0, 1'b1);
    checks++;
    if (dut_out() !== 7'd0) begin
      failures++; $display("FAIL reset_mid_urgent got=%b exp=%b", dut_out(), 7'd0);
    end
  endtask

  task automatic test_coincident();
    ak = 1'b0; wl = 4'd8;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < AT; i++) step(1'b0, 1'b0);
    ak = 1'b1;
    step(1'b0, 1'b0);
    ak = 1'b0;
    for (int i = 0; i < HO + 1; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < AT - 1; i++) step(1'b0, 1'b0);
    ak = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if (dut_out() !== {3'b000, 4'd1}) begin
      failures++; $display("FAIL coincident got=%b exp=%b", dut_out(), {3'b000, 4'd1});
    end
  endtask

  task automatic test_random();
    logic r, rs;
    ak = 1'b0; wl = 4'd8;
    step(1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      r  = (($urandom % 10) == 0);
      rs = (($urandom % 500) == 0);
      if (($urandom % 16) == 0) wl = 4'($urandom);
      if (($urandom % 12) == 0) ak = ~ak;
      step(r, rs);
      checks++;
      if (dut_out() !== exp_out()) begin
        failures++; $display("FAIL random_cycle%0d got=%b exp=%b", n, dut_out(), exp_out());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_escalation();
    test_ack_holdoff();
    test_drop();
    test_ack_held();
    test_saturation();
    test_coincident();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
